// File: rtl/alu_wb_stage.sv
// alu_wb_stage: one-entry writeback register behind the ALU.
// It evaluates the condition code against the NZCV register, owns that
// register, and uses a valid/ready handshake with full throughput.
// Optional annulled-instruction counter: define WB_ANNUL_STATS_EN to build it.
module alu_wb_stage #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    input  logic         set_flags,
    input  logic [3:0]   cond,
    input  logic [3:0]   rd,
    input  logic         reg_write,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] wb_result,
    output logic [3:0]   wb_rd,
    output logic         wb_we,
    output logic [3:0]   flags_q,
    output logic [7:0]   annul_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   wb_result_q, wb_result_d;
    logic [3:0]     wb_rd_q, wb_rd_d;
    logic           wb_we_q, wb_we_d;
    logic [3:0]     flags_d;
    logic           xfer;
    logic           cond_pass;
    logic           f_n, f_z, f_c, f_v;

    // Accept while empty, while the entry drains this cycle, or during reset
    assign in_ready = !rst_n || !out_valid || out_ready;
    assign xfer     = in_valid && in_ready && rst_n;

    assign f_n = flags_q[3];
    assign f_z = flags_q[2];
    assign f_c = flags_q[1];
    assign f_v = flags_q[0];

    // Condition check against the flags as they stand before this instruction
    always_comb begin
        cond_pass = 1'b1;
        case (cond)
            4'h0: cond_pass = f_z;
            4'h1: cond_pass = !f_z;
            4'h2: cond_pass = f_c;
            4'h3: cond_pass = !f_c;
            4'h4: cond_pass = f_n;
            4'h5: cond_pass = !f_n;
            4'h6: cond_pass = f_v;
            4'h7: cond_pass = !f_v;
            4'h8: cond_pass = f_c && !f_z;
            4'h9: cond_pass = !f_c || f_z;
            4'hA: cond_pass = (f_n == f_v);
            4'hB: cond_pass = (f_n != f_v);
            4'hC: cond_pass = !f_z && (f_n == f_v);
            4'hD: cond_pass = f_z || (f_n != f_v);
            default: cond_pass = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a transfer fills, a drain without refill empties
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (xfer) state_d = FULL;
            FULL:  if (out_ready && !xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output decode
    always_comb begin
        out_valid = 1'b0;
        if (state_q == FULL) out_valid = 1'b1;
    end

    // Writeback entry and flag register next values
    always_comb begin
        wb_result_d = wb_result_q;
        wb_rd_d     = wb_rd_q;
        wb_we_d     = wb_we_q;
        flags_d     = flags_q;
        if (xfer) begin
            wb_result_d = alu_result;
            wb_rd_d     = rd;
            wb_we_d     = reg_write && cond_pass;
            if (set_flags && cond_pass) flags_d = alu_flags;
        end
    end

    // Writeback entry and flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_result_q <= '0;
            wb_rd_q     <= 4'h0;
            wb_we_q     <= 1'b0;
            flags_q     <= 4'h0;
        end else begin
            wb_result_q <= wb_result_d;
            wb_rd_q     <= wb_rd_d;
            wb_we_q     <= wb_we_d;
            flags_q     <= flags_d;
        end
    end

    assign wb_result = wb_result_q;
    assign wb_rd     = wb_rd_q;
    assign wb_we     = wb_we_q;

`ifdef WB_ANNUL_STATS_EN
    logic [7:0] annul_count_q, annul_count_d;

    // Saturating count of accepted instructions that failed their condition
    always_comb begin
        annul_count_d = annul_count_q;
        if (xfer && !cond_pass && (annul_count_q != 8'hFF)) begin
            annul_count_d = annul_count_q + 8'd1;
        end
    end

    // Annul counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            annul_count_q <= 8'h00;
        end else begin
            annul_count_q <= annul_count_d;
        end
    end

    assign annul_count = annul_count_q;
`else
    assign annul_count = 8'h00;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: directed vector table plus hand sequences for the
// stall, reset-while-full and counter-saturation cases.
module tb_alu_wb_stage;

    localparam int unsigned N = 4;
`ifdef WB_ANNUL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic         set_flags;
    logic [3:0]   cond;
    logic [3:0]   rd;
    logic         reg_write;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] wb_result;
    logic [3:0]   wb_rd;
    logic         wb_we;
    logic [3:0]   flags_q;
    logic [7:0]   annul_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_wb_stage #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .set_flags   (set_flags),
        .cond        (cond),
        .rd          (rd),
        .reg_write   (reg_write),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .wb_result   (wb_result),
        .wb_rd       (wb_rd),
        .wb_we       (wb_we),
        .flags_q     (flags_q),
        .annul_count (annul_count)
    );

    typedef struct {
        logic         vld;
        logic [N-1:0] res;
        logic [3:0]   fl;
        logic         sf;
        logic [3:0]   cc;
        logic [3:0]   rdi;
        logic         rw;
        logic         ordy;
        logic         e_irdy;
        logic         e_ov;
        logic [N-1:0] e_res;
        logic [3:0]   e_rd;
        logic         e_we;
        logic [3:0]   e_fl;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [N-1:0] res, input logic [3:0] fl,
                         input logic sf, input logic [3:0] cc, input logic [3:0] rdi,
                         input logic rw, input logic ordy);
        in_valid   = vld;
        alu_result = res;
        alu_flags  = fl;
        set_flags  = sf;
        cond       = cc;
        rd         = rdi;
        reg_write  = rw;
        out_ready  = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic ov, input logic [N-1:0] res,
                          input logic [3:0] rdi, input logic we);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".wb_result"}, 32'(wb_result), 32'(res));
        chk({tag, ".wb_rd"},     32'(wb_rd),     32'(rdi));
        chk({tag, ".wb_we"},     32'(wb_we),     32'(we));
    endtask

    initial begin
        //          vld res   fl     sf  cc    rd    rw  ordy irdy ov  res   rd    we  flags
        vecs[0]  = '{1, 4'h4, 4'h0, 0, 4'hE, 4'h3, 1, 1,   1,   1, 4'h4, 4'h3, 1, 4'h0}; // always
        vecs[1]  = '{1, 4'h0, 4'h4, 1, 4'hE, 4'h1, 1, 1,   1,   1, 4'h0, 4'h1, 1, 4'h4}; // set Z
        vecs[2]  = '{1, 4'h5, 4'h0, 0, 4'h0, 4'h2, 1, 1,   1,   1, 4'h5, 4'h2, 1, 4'h4}; // EQ pass
        vecs[3]  = '{1, 4'h6, 4'h8, 1, 4'h1, 4'h4, 1, 1,   1,   1, 4'h6, 4'h4, 0, 4'h4}; // NE annul
        vecs[4]  = '{0, 4'h9, 4'h0, 0, 4'hE, 4'h0, 1, 1,   1,   0, 4'h6, 4'h4, 0, 4'h4}; // drain
        vecs[5]  = '{1, 4'h7, 4'h2, 1, 4'h9, 4'h5, 1, 1,   1,   1, 4'h7, 4'h5, 1, 4'h2}; // LS pass
        vecs[6]  = '{1, 4'h8, 4'h9, 1, 4'h8, 4'h6, 1, 1,   1,   1, 4'h8, 4'h6, 1, 4'h9}; // HI pass
        vecs[7]  = '{1, 4'h9, 4'h0, 1, 4'hB, 4'h7, 1, 1,   1,   1, 4'h9, 4'h7, 0, 4'h9}; // LT annul
        vecs[8]  = '{1, 4'hA, 4'h8, 1, 4'hC, 4'h8, 0, 1,   1,   1, 4'hA, 4'h8, 0, 4'h8}; // GT pass, rw=0
        vecs[9]  = '{1, 4'hB, 4'h0, 0, 4'hD, 4'h9, 1, 1,   1,   1, 4'hB, 4'h9, 1, 4'h8}; // LE pass
        vecs[10] = '{1, 4'hC, 4'h1, 1, 4'h4, 4'hA, 1, 1,   1,   1, 4'hC, 4'hA, 1, 4'h1}; // MI pass
        vecs[11] = '{1, 4'hD, 4'h0, 1, 4'h7, 4'hB, 1, 1,   1,   1, 4'hD, 4'hB, 0, 4'h1}; // VC annul
        vecs[12] = '{1, 4'hE, 4'h0, 1, 4'h6, 4'hC, 1, 1,   1,   1, 4'hE, 4'hC, 1, 4'h0}; // VS pass
        vecs[13] = '{1, 4'hF, 4'h0, 0, 4'h3, 4'hD, 1, 1,   1,   1, 4'hF, 4'hD, 1, 4'h0}; // CC pass
        vecs[14] = '{1, 4'h1, 4'h0, 0, 4'h2, 4'hE, 1, 1,   1,   1, 4'h1, 4'hE, 0, 4'h0}; // CS annul
        vecs[15] = '{1, 4'h2, 4'h0, 0, 4'h5, 4'hF, 1, 1,   1,   1, 4'h2, 4'hF, 1, 4'h0}; // PL pass
        vecs[16] = '{1, 4'h3, 4'hA, 1, 4'hF, 4'h0, 1, 1,   1,   1, 4'h3, 4'h0, 1, 4'hA}; // always, set NC.V

        rst_n = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 1'b0, 4'hE, 4'h0, 1'b0, 1'b1);
        tick();
        tick();
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk_wb("reset", 1'b0, 4'h0, 4'h0, 1'b0);
        chk("reset.flags", 32'(flags_q), 32'h0);
        chk("reset.annul", 32'(annul_count), 32'h0);
        rst_n = 1'b1;

        // Table: in_ready before the edge, entry and flags after it
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].vld, vecs[i].res, vecs[i].fl, vecs[i].sf, vecs[i].cc,
                  vecs[i].rdi, vecs[i].rw, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_irdy));
            tick();
            chk_wb($sformatf("v%0d", i), vecs[i].e_ov, vecs[i].e_res, vecs[i].e_rd, vecs[i].e_we);
            chk($sformatf("v%0d.flags", i), 32'(flags_q), 32'(vecs[i].e_fl));
        end
        chk("table.annul", 32'(annul_count), STATS ? 32'd4 : 32'd0);

        // Stall two cycles while full: entry must hold, inputs ignored
        drive(1'b1, 4'h5, 4'h0, 1'b1, 4'hE, 4'h1, 1'b1, 1'b0);
        #1;
        chk("stall1.in_ready", 32'(in_ready), 32'd0);
        tick();
        chk_wb("stall1", 1'b1, 4'h3, 4'h0, 1'b1);
        chk("stall1.flags", 32'(flags_q), 32'hA);
        drive(1'b1, 4'h6, 4'h0, 1'b1, 4'hE, 4'h9, 1'b1, 1'b0);
        #1;
        chk("stall2.in_ready", 32'(in_ready), 32'd0);
        tick();
        chk_wb("stall2", 1'b1, 4'h3, 4'h0, 1'b1);
        drive(1'b1, 4'h7, 4'h0, 1'b0, 4'hE, 4'h2, 1'b1, 1'b1);
        #1;
        chk("release.in_ready", 32'(in_ready), 32'd1);
        tick();
        chk_wb("release", 1'b1, 4'h7, 4'h2, 1'b1);
        chk("release.flags", 32'(flags_q), 32'hA);

        // Reset while full with a stalled consumer and a pending input
        drive(1'b1, 4'h9, 4'hF, 1'b1, 4'hE, 4'h5, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_full.in_ready", 32'(in_ready), 32'd1);
        tick();
        chk_wb("rst_full", 1'b0, 4'h0, 4'h0, 1'b0);
        chk("rst_full.flags", 32'(flags_q), 32'h0);
        chk("rst_full.annul", 32'(annul_count), 32'h0);
        rst_n = 1'b1;

        // 260 annulled transfers: EQ with Z clear always fails
        drive(1'b1, 4'h1, 4'hF, 1'b1, 4'h0, 4'h3, 1'b1, 1'b1);
        for (int i = 0; i < 254; i++) tick();
        chk("sat.254", 32'(annul_count), STATS ? 32'd254 : 32'd0);
        tick();
        chk("sat.255", 32'(annul_count), STATS ? 32'd255 : 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("sat.hold", 32'(annul_count), STATS ? 32'd255 : 32'd0);
        chk_wb("sat", 1'b1, 4'h1, 4'h3, 1'b0);
        chk("sat.flags", 32'(flags_q), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning ALU data width (matches the ALU's N).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 The block SHALL have port in_valid  input  1  upstream ALU result valid.
REQ-005 The block SHALL have port in_ready  output  1  stage can accept a result this cycle.
REQ-006 The block SHALL have port alu_result  input  N  ALU_Result from the ALU.
REQ-007 The block SHALL have port alu_flags  input  4  ALU_Flags from the ALU, bit3=N, bit2=Z, bit1=C, bit0=V.
REQ-008 The block SHALL have port set_flags  input  1  instruction updates the flag register.
REQ-009 The block SHALL have port cond  input  4  condition code gating the instruction.
REQ-010 The block SHALL have port rd  input  4  destination register index.
REQ-011 The block SHALL have port reg_write  input  1  instruction writes rd.
REQ-012 The block SHALL have port out_valid  output  1  writeback entry held.
REQ-013 The block SHALL have port out_ready  input  1  register file consumes the entry.
REQ-014 The block SHALL have port wb_result  output  N  registered result.
REQ-015 The block SHALL have port wb_rd  output  4  registered destination.
REQ-016 The block SHALL have port wb_we  output  1  registered write enable, reg_write AND cond_pass.
REQ-017 The block SHALL have port flags_q  output  4  architectural NZCV register.
REQ-018 The block SHALL have port annul_count  output  8  annulled-instruction counter.

Function
REQ-019 The block SHALL implement states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-020 The block SHALL drive in_ready = !out_valid || out_ready (combinational).
REQ-021 A transfer SHALL occur when in_valid && in_ready; it loads wb_result, wb_rd, wb_we on that edge and enters FULL: latency 1 cycle.
REQ-022 In FULL with out_ready=1 and no transfer, the block SHALL go to EMPTY; with out_ready=1 and a transfer, it SHALL stay FULL with the new entry (full throughput, no bubble).
REQ-023 In FULL with out_ready=0, the block SHALL hold all wb_* outputs stable and ignore alu_* inputs.
REQ-024 cond_pass SHALL be evaluated on flags_q at the transfer cycle, before any update by that instruction: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E, F always.
REQ-025 On a transfer with set_flags=1 and cond_pass=1, flags_q SHALL load alu_flags on that edge; otherwise flags_q holds.
REQ-026 An annulled instruction (cond_pass=0) SHALL still occupy the stage with wb_we=0 and wb_result loaded.
REQ-027 Back-to-back transfers SHALL see the flags written by the preceding accepted instruction.

Reset
REQ-028 When rst_n=0 at a clock edge, the block SHALL set out_valid=0, wb_result=0, wb_rd=0, wb_we=0, flags_q=4'b0000, annul_count=0, discarding any held entry.
REQ-029 While rst_n=0, in_ready SHALL be 1 and no transfer SHALL take effect.

Configuration
REQ-030 With macro WB_ANNUL_STATS_EN defined, annul_count SHALL increment by 1 on each transfer with cond_pass=0 and saturate at 8'hFF.
REQ-031 Without WB_ANNUL_STATS_EN, annul_count SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-032 After reset, transfer alu_result=4'b0100, alu_flags=4'b0000, cond=E, reg_write=1, rd=3, out_ready=1 -> next cycle out_valid=1, wb_result=0100, wb_rd=3, wb_we=1.
REQ-033 Transfer result 0000, flags 0100, set_flags=1, cond=E, then cond=0 (EQ), reg_write=1 -> flags_q=0100, second entry wb_we=1.
REQ-034 With flags_q=0100, transfer cond=1 (NE), reg_write=1 -> wb_we=0, flags_q unchanged, annul_count=1 with WB_ANNUL_STATS_EN, 0 without.
REQ-035 Hold out_ready=0 two cycles while FULL, in_valid=1 with changing data -> in_ready=0, wb_* unchanged; release -> next entry loaded on the release edge.
REQ-036 Assert rst_n=0 for one edge while FULL with flags_q=1010 -> out_valid=0, flags_q=0000, annul_count=0 next cycle.
REQ-037 Issue 256 annulled transfers with WB_ANNUL_STATS_EN -> annul_count saturates at 8'hFF.
